// File: rtl/vram_port_arbiter.sv
// VRAM port arbiter: round-robin reads from N_REQ display layers during active video,
// with CPU writes admitted only in vertical blanking after the read pipeline drains.
module vram_port_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic                    pclk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        i_rd_req,
    input  logic [N_REQ*ADDR_W-1:0] i_rd_addr,
    output logic [N_REQ-1:0]        o_rd_gnt,
    output logic [N_REQ-1:0]        o_rd_valid,
    output logic [DATA_W-1:0]       o_rd_data,
    input  logic                    i_frame_blank,
    input  logic                    i_wr_req,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [DATA_W-1:0]       i_wr_data,
    output logic                    o_wr_gnt,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic [DATA_W-1:0]       o_mem_din,
    input  logic [DATA_W-1:0]       i_mem_dout
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {ACTIVE, DRAIN, BLANK} state_t;

    state_t            r_state;
    logic [2:0]        r_drain_cnt;
    logic [PTR_W-1:0]  r_ptr;
    logic [N_REQ-1:0]  r_rd_gnt;
    logic              r_wr_gnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic [N_REQ-1:0]  r_tag [RD_LAT];

    logic [ADDR_W-1:0] w_addr_arr [N_REQ];
    logic [N_REQ-1:0]  w_rd_elig;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  w_rd_idx;
    logic              w_rd_any;
    logic              w_do_rd;
    logic              w_do_wr;
    logic              w_drain_done;

    for (genvar g = 0; g < N_REQ; g++) begin : g_addr
        assign w_addr_arr[g] = i_rd_addr[g*ADDR_W +: ADDR_W];
    end

    // A requester still holding req during its grant cycle must not win twice.
    assign w_rd_elig    = i_rd_req & ~r_rd_gnt;
    assign w_drain_done = (r_drain_cnt == 3'(RD_LAT - 1));

    always_comb begin
        w_rd_any = 1'b0;
        w_rd_idx = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_rd_any && w_rd_elig[w_idx]) begin
                w_rd_any = 1'b1;
                w_rd_idx = w_idx;
            end
        end
    end

    // A falling frame_blank hands the port back to reads on the same edge.
    always_comb begin
        w_do_rd = 1'b0;
        w_do_wr = 1'b0;
        case (r_state)
            ACTIVE: w_do_rd = !i_frame_blank;
            DRAIN, BLANK: begin
                if (!i_frame_blank) begin
                    w_do_rd = 1'b1;
                end else if (r_state == BLANK || w_drain_done) begin
                    w_do_wr = i_wr_req;
                    w_do_rd = !i_wr_req;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= ACTIVE;
            r_drain_cnt <= '0;
            r_ptr       <= '0;
            r_rd_gnt    <= '0;
            r_wr_gnt    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            for (int k = 0; k < RD_LAT; k++) r_tag[k] <= '0;
        end else begin
            r_rd_gnt   <= '0;
            r_wr_gnt   <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_tag[0]   <= r_rd_gnt;
            for (int k = 1; k < RD_LAT; k++) r_tag[k] <= r_tag[k-1];

            if (w_do_wr) begin
                r_wr_gnt   <= 1'b1;
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b1;
                r_mem_addr <= i_wr_addr;
                r_mem_din  <= i_wr_data;
            end else if (w_do_rd && w_rd_any) begin
                r_rd_gnt   <= N_REQ'(1) << w_rd_idx;
                r_mem_en   <= 1'b1;
                r_mem_addr <= w_addr_arr[w_rd_idx];
                r_ptr      <= PTR_W'((int'(w_rd_idx) + 1) % N_REQ);
            end

            case (r_state)
                ACTIVE: begin
                    if (i_frame_blank) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (!i_frame_blank)    r_state <= ACTIVE;
                    else if (w_drain_done) r_state <= BLANK;
                    else                   r_drain_cnt <= r_drain_cnt + 3'd1;
                end
                BLANK: if (!i_frame_blank) r_state <= ACTIVE;
                default: r_state <= ACTIVE;
            endcase
        end
    end

    assign o_rd_gnt   = r_rd_gnt;
    assign o_rd_valid = r_tag[RD_LAT-1];
    assign o_rd_data  = (|r_tag[RD_LAT-1]) ? i_mem_dout : '0;
    assign o_wr_gnt   = r_wr_gnt;
    assign o_mem_en   = r_mem_en;
    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_din  = r_mem_din;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: directed vector table, corner sequences, and random
// traffic scored against a transaction-level model with a synthetic memory.
module tb_vram_port_arbiter;
    localparam int N   = 4;
    localparam int AW  = 17;
    localparam int DW  = 12;
    localparam int LAT = 2;

    logic            pclk;
    logic            reset;
    logic [N-1:0]    rd_req;
    logic [N*AW-1:0] rd_addr;
    logic [N-1:0]    o_rd_gnt;
    logic [N-1:0]    o_rd_valid;
    logic [DW-1:0]   o_rd_data;
    logic            frame_blank;
    logic            wr_req;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            o_wr_gnt;
    logic            o_mem_en;
    logic            o_mem_we;
    logic [AW-1:0]   o_mem_addr;
    logic [DW-1:0]   o_mem_din;
    logic [DW-1:0]   mem_dout;

    int errors = 0;
    int checks = 0;

    vram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .pclk(pclk), .reset(reset),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr),
        .o_rd_gnt(o_rd_gnt), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .i_frame_blank(frame_blank),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(o_wr_gnt),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_din(o_mem_din), .i_mem_dout(mem_dout)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Memory contents are a fixed function of address; data emerges LAT cycles after mem_en.
    function automatic logic [DW-1:0] fmem(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 12'hFAA;
    endfunction

    logic [AW-1:0] dq [LAT];
    always @(posedge pclk) begin
        dq[0] <= o_mem_addr;
        for (int k = 1; k < LAT; k++) dq[k] <= dq[k-1];
    end
    assign mem_dout = fmem(dq[LAT-1]);

    // Reference model: expected outputs for the next cycle, pending returns by due cycle.
    typedef struct { int due; int idx; logic [AW-1:0] addr; } ret_t;
    ret_t pend[$];
    int   m_mode;     // 0 active video, 1 draining, 2 blanking
    int   m_drained;  // idle drain cycles already emitted
    int   m_ptr;
    int   cyc = 0;
    logic [N-1:0]  e_gnt = '0, e_valid = '0;
    logic [DW-1:0] e_data = '0, e_din = '0;
    logic [AW-1:0] e_addr = '0;
    logic          e_wgnt = 1'b0, e_en = 1'b0, e_we = 1'b0;

    task automatic model_step();
        logic [N-1:0] prev_gnt;
        logic [N-1:0] elig;
        bit may_rd;
        bit may_wr;
        prev_gnt = e_gnt;
        e_gnt = '0; e_valid = '0; e_data = '0; e_wgnt = 1'b0;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
        may_rd = 1'b0; may_wr = 1'b0;
        if (reset) begin
            pend.delete();
            m_mode = 0; m_drained = 0; m_ptr = 0;
        end else begin
            if (pend.size() != 0 && pend[0].due == cyc + 1) begin
                e_valid[pend[0].idx] = 1'b1;
                e_data = fmem(pend[0].addr);
                void'(pend.pop_front());
            end
            if (m_mode == 0) begin
                if (frame_blank) begin m_mode = 1; m_drained = 1; end
                else may_rd = 1'b1;
            end else if (!frame_blank) begin
                m_mode = 0; may_rd = 1'b1;
            end else if (m_mode == 1 && m_drained < LAT) begin
                m_drained++;
            end else begin
                m_mode = 2; may_wr = wr_req; may_rd = !wr_req;
            end
            if (may_wr) begin
                e_wgnt = 1'b1; e_en = 1'b1; e_we = 1'b1; e_addr = wr_addr; e_din = wr_data;
            end else if (may_rd) begin
                elig = rd_req & ~prev_gnt;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (elig[idx]) begin
                        e_gnt[idx] = 1'b1;
                        e_en = 1'b1;
                        e_addr = rd_addr[idx*AW +: AW];
                        m_ptr = (idx + 1) % N;
                        pend.push_back('{cyc + 1 + LAT, idx, e_addr});
                        break;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_all();
        return 64'({o_rd_gnt, o_rd_valid, o_rd_data, o_wr_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_din});
    endfunction

    function automatic logic [63:0] exp_all();
        return 64'({e_gnt, e_valid, e_data, e_wgnt, e_en, e_we, e_addr, e_din});
    endfunction

    task automatic do_reset();
        reset = 1'b1; rd_req = '0; wr_req = 1'b0; frame_blank = 1'b0;
        tick();
        tick();
        chk("reset_outputs", dut_all(), 64'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] req; logic fb; logic wr;
        logic [N-1:0] gnt; logic [N-1:0] vld; logic wgnt; logic en; logic we;
    } vec_t;
    vec_t tv [15];

    initial begin
        int fb_left;
        reset = 1'b1; rd_req = '0; rd_addr = '0; frame_blank = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;

        // req, fb, wr | gnt, valid, wr_gnt, en, we
        tv[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 4'b0001, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 4'b0010, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{4'b1000, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1};
        tv[10] = '{4'b0011, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1};
        tv[11] = '{4'b0011, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1};
        tv[12] = '{4'b0011, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0};
        tv[13] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0};
        tv[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = AW'(17'h100 * (i + 1) + 17'h10);
        wr_addr = 17'h1ABCD; wr_data = 12'h5C3;
        for (int r = 0; r < 15; r++) begin
            rd_req = tv[r].req; frame_blank = tv[r].fb; wr_req = tv[r].wr;
            tick();
            chk($sformatf("vec%0d", r),
                64'({o_rd_gnt, o_rd_valid, o_wr_gnt, o_mem_en, o_mem_we}),
                64'({tv[r].gnt, tv[r].vld, tv[r].wgnt, tv[r].en, tv[r].we}));
        end

        // Single requester: address, grant, and data return after LAT cycles.
        do_reset();
        rd_req = 4'b0100; rd_addr[2*AW +: AW] = 17'h000A5;
        tick();
        chk("single_issue", 64'({o_rd_gnt, o_mem_en, o_mem_we, o_mem_addr}),
            64'({4'b0100, 1'b1, 1'b0, 17'h000A5}));
        rd_req = '0;
        tick();
        chk("single_wait", 64'(o_rd_valid), 64'd0);
        tick();
        chk("single_return", 64'({o_rd_valid, o_rd_data}), 64'({4'b0100, 12'hF0F}));

        // Reset right after a grant: in-flight read vanishes, pointer restarts at 0.
        do_reset();
        rd_req = 4'b0100;
        tick();
        chk("rst_pre_gnt", 64'(o_rd_gnt), 64'(4'b0100));
        rd_req = '0; reset = 1'b1;
        tick();
        chk("rst_outputs0", dut_all(), 64'd0);
        tick();
        chk("rst_outputs1", dut_all(), 64'd0);
        reset = 1'b0; rd_req = 4'b1111;
        tick();
        chk("rst_first_gnt", 64'({o_rd_gnt, o_rd_valid}), 64'({4'b0001, 4'b0000}));
        rd_req = '0;
        tick();
        chk("rst_no_stale", 64'(o_rd_valid), 64'd0);
        tick();
        chk("rst_new_valid", 64'(o_rd_valid), 64'(4'b0001));

        // frame_blank falls during a write grant: no further write, reads resume.
        do_reset();
        frame_blank = 1'b1; wr_req = 1'b1; wr_addr = 17'h1F00A; wr_data = 12'h123;
        tick();
        chk("drain_idle0", 64'(o_mem_en), 64'd0);
        tick();
        chk("drain_idle1", 64'(o_mem_en), 64'd0);
        tick();
        chk("blank_write", 64'({o_wr_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_din}),
            64'({1'b1, 1'b1, 1'b1, 17'h1F00A, 12'h123}));
        frame_blank = 1'b0; rd_req = 4'b0001; rd_addr[0 +: AW] = 17'h00777;
        tick();
        chk("blank_exit", 64'({o_wr_gnt, o_mem_we, o_rd_gnt, o_mem_en, o_mem_addr}),
            64'({1'b0, 1'b0, 4'b0001, 1'b1, 17'h00777}));

        // frame_blank glitch during drain: straight back to reads, no write.
        do_reset();
        frame_blank = 1'b1; wr_req = 1'b1;
        tick();
        chk("glitch_drain", 64'(o_mem_en), 64'd0);
        frame_blank = 1'b0; rd_req = 4'b0010;
        tick();
        chk("glitch_exit", 64'({o_wr_gnt, o_mem_we, o_rd_gnt}), 64'({1'b0, 1'b0, 4'b0010}));

        // Random traffic against the reference model.
        do_reset();
        fb_left = 5;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (e_gnt[i] || !rd_req[i]) begin
                    rd_req[i] = ($urandom_range(0, 2) != 0);
                    rd_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            if (e_wgnt || !wr_req) begin
                wr_req = $urandom_range(0, 1) != 0;
                wr_addr = AW'($urandom);
                wr_data = DW'($urandom);
            end
            if (fb_left == 0) begin
                frame_blank = ~frame_blank;
                fb_left = $urandom_range(1, 12);
            end else begin
                fb_left--;
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
            chk("random", dut_all(), exp_all());
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vram_port_arbiter.md
VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of read requesters (sprite/background layers).
REQ-002 Parameter ADDR_W, default 17: memory address width.
REQ-003 Parameter DATA_W, default 12: pixel word width (4:4:4 RGB).
REQ-004 Parameter RD_LAT, default 2: memory read latency in pclk cycles, 1..4.
REQ-005 Ports: pclk  in  1  pixel clock; reset  in  1  reset, synchronous, active-high.
REQ-006 Port rd_req  in  N_REQ: per-requester read request, held until granted.
REQ-007 Port rd_addr  in  N_REQ*ADDR_W: packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-008 Port rd_gnt  out  N_REQ: one-hot, one-cycle grant pulse.
REQ-009 Port rd_valid  out  N_REQ: one-hot, one-cycle read-data-valid pulse.
REQ-010 Port rd_data  out  DATA_W: read data, qualified by rd_valid.
REQ-011 Port frame_blank  in  1: high during vertical blanking (from the VGA timing block).
REQ-012 Ports wr_req  in  1; wr_addr  in  ADDR_W; wr_data  in  DATA_W; wr_gnt  out  1 (one-cycle pulse).
REQ-013 Ports mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_din  out  DATA_W; mem_dout  in  DATA_W.

Function
REQ-014 State machine with states ACTIVE, DRAIN, BLANK; the reset state SHALL be ACTIVE.
REQ-015 ACTIVE: reads only; wr_req SHALL be ignored (held pending, never granted).
REQ-016 ACTIVE -> DRAIN when frame_blank is sampled high; DRAIN issues no memory access for RD_LAT cycles, then -> BLANK.
REQ-017 BLANK: wr_req has absolute priority over reads; when wr_req=0, reads are arbitrated as in ACTIVE.
REQ-018 BLANK -> ACTIVE when frame_blank is sampled low; a write issued in that same cycle still completes; no new write is granted afterwards.
REQ-019 Read arbitration: round-robin; search starts at index (last granted + 1) mod N_REQ; after reset the pointer is 0, so index 0 wins first.
REQ-020 The requester whose rd_gnt is currently high SHALL be excluded from the current arbitration cycle (no double grant on a held req).
REQ-021 Issue latency: a request sampled at edge t SHALL produce, at edge t+1, mem_en=1, mem_addr=that requester's address, and rd_gnt[i]=1, all registered.
REQ-022 At most one memory access per cycle; mem_en=0 when nothing is granted.
REQ-023 Read return: rd_valid[i]=1 and rd_data=mem_dout exactly RD_LAT cycles after the mem_en cycle; a tag shift register of depth RD_LAT carries the index.
REQ-024 Write: granted at t+1 with mem_en=1, mem_we=1, mem_addr=wr_addr, mem_din=wr_data, wr_gnt=1; writes produce no rd_valid.
REQ-025 mem_we SHALL be 0 in every cycle that is not a write grant.
REQ-026 Simultaneous rd_req and wr_req in BLANK: the write wins; the round-robin pointer is unchanged.
REQ-027 A frame_blank toggle during DRAIN SHALL return the block to ACTIVE immediately, with no write granted.

Reset
REQ-028 During reset all outputs SHALL be 0: rd_gnt, rd_valid, rd_data, wr_gnt, mem_en, mem_we, mem_addr, mem_din.
REQ-029 Reset SHALL set the state to ACTIVE, the RR pointer to 0, and clear the return-tag pipeline.
REQ-030 Reads in flight when reset is asserted SHALL be discarded, with no rd_valid after reset.

Verification
REQ-031 rd_req=4'b1111 held, frame_blank=0 -> rd_gnt sequence 0001,0010,0100,1000,0001; rd_valid follows each grant by RD_LAT=2 cycles.
REQ-032 rd_req[2] only, addr=17'h00A5 -> at the next edge mem_addr=0x00A5, mem_en=1, rd_gnt=0100; with mem_dout=12'hF0F two cycles later, rd_valid=0100 and rd_data=0xF0F.
REQ-033 wr_req=1 with frame_blank=0 -> wr_gnt stays 0; raise frame_blank -> 2 DRAIN cycles with mem_en=0, then wr_gnt=1, mem_we=1.
REQ-034 In BLANK with wr_req=1 and rd_req=4'b0011 -> writes granted every cycle, reads starved; drop wr_req -> rd_gnt=0001 next (pointer preserved).
REQ-035 Assert reset one cycle after a read grant -> no rd_valid appears; all outputs 0; the first grant after release goes to index 0.
REQ-036 frame_blank falls in the same cycle as a write grant -> that write completes; a wr_req still held is not granted; reads resume the next cycle.
